zigzag_pingpong_ctrl: RTL and testbench

- Continuous-stream 8x8 zigzag scan controller.
- Owns two external 64x10 sram banks (ADDR_DEPTH 6, DATA_DEPTH 64) in ping-pong: one bank fills in raster order while the other drains in zigzag order.
- Sits between the quantiser output and the run-length coder.
- Valid/ready on both sides: 2-entry output FIFO absorbs downstream stalls; input backpressure only when both banks are occupied.

---
 rtl/zigzag_pingpong_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_zigzag_pingpong_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_pingpong_ctrl.sv
// Ping-pong 8x8 zigzag scan controller.
// Raster fill into one bank, zigzag drain of the other.
module zigzag_pingpong_ctrl #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_in,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  vld_out,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  blk_last,
  output logic                  b0_cs_n,
  output logic                  b0_w_en,
  output logic                  b0_r_en,
  output logic [5:0]            b0_addr,
  output logic [DATA_WIDTH-1:0] b0_din,
  input  logic [DATA_WIDTH-1:0] b0_dout,
  output logic                  b1_cs_n,
  output logic                  b1_w_en,
  output logic                  b1_r_en,
  output logic [5:0]            b1_addr,
  output logic [DATA_WIDTH-1:0] b1_din,
  input  logic [DATA_WIDTH-1:0] b1_dout
);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

  bank_st_t st0, st1, st0_nxt, st1_nxt;
  bank_st_t wst, rst_st;

  logic       wr_bank, rd_bank;
  logic [5:0] wcnt, rcnt, zaddr;
  logic       accept, issue, pop, credit;
  logic       wfin, rfin, rd_act;
  logic       pend, pend_bank, pend_last;
  logic [2:0] need;

  logic [DATA_WIDTH-1:0] fd [2];
  logic                  fl [2];
  logic                  head, tail;
  logic [1:0]            fcnt;
  logic [DATA_WIDTH-1:0] pdata;

  logic wsel0, wsel1, rsel0, rsel1;

  function automatic logic [5:0] zz(input logic [5:0] k);
    logic [5:0] a;
    case (k)
      6'd0:  a = 6'd0;  6'd1:  a = 6'd1;
      6'd2:  a = 6'd8;  6'd3:  a = 6'd16;
      6'd4:  a = 6'd9;  6'd5:  a = 6'd2;
      6'd6:  a = 6'd3;  6'd7:  a = 6'd10;
      6'd8:  a = 6'd17; 6'd9:  a = 6'd24;
      6'd10: a = 6'd32; 6'd11: a = 6'd25;
      6'd12: a = 6'd18; 6'd13: a = 6'd11;
      6'd14: a = 6'd4;  6'd15: a = 6'd5;
      6'd16: a = 6'd12; 6'd17: a = 6'd19;
      6'd18: a = 6'd26; 6'd19: a = 6'd33;
      6'd20: a = 6'd40; 6'd21: a = 6'd48;
      6'd22: a = 6'd41; 6'd23: a = 6'd34;
      6'd24: a = 6'd27; 6'd25: a = 6'd20;
      6'd26: a = 6'd13; 6'd27: a = 6'd6;
      6'd28: a = 6'd7;  6'd29: a = 6'd14;
      6'd30: a = 6'd21; 6'd31: a = 6'd28;
      6'd32: a = 6'd35; 6'd33: a = 6'd42;
      6'd34: a = 6'd49; 6'd35: a = 6'd56;
      6'd36: a = 6'd57; 6'd37: a = 6'd50;
      6'd38: a = 6'd43; 6'd39: a = 6'd36;
      6'd40: a = 6'd29; 6'd41: a = 6'd22;
      6'd42: a = 6'd15; 6'd43: a = 6'd23;
      6'd44: a = 6'd30; 6'd45: a = 6'd37;
      6'd46: a = 6'd44; 6'd47: a = 6'd51;
      6'd48: a = 6'd58; 6'd49: a = 6'd59;
      6'd50: a = 6'd52; 6'd51: a = 6'd45;
      6'd52: a = 6'd38; 6'd53: a = 6'd31;
      6'd54: a = 6'd39; 6'd55: a = 6'd46;
      6'd56: a = 6'd53; 6'd57: a = 6'd60;
      6'd58: a = 6'd61; 6'd59: a = 6'd54;
      6'd60: a = 6'd47; 6'd61: a = 6'd55;
      6'd62: a = 6'd62; 6'd63: a = 6'd63;
      default: a = 6'd0;
    endcase
    return a;
  endfunction

  // Handshake, read credit and FIFO head decode
  always_comb begin
    wst     = wr_bank ? st1 : st0;
    rst_st  = rd_bank ? st1 : st0;
    in_rdy  = (wst == EMPTY) || (wst == FILLING);
    accept  = vld_in && in_rdy;
    wfin    = accept && (wcnt == 6'd63);
    vld_out = (fcnt != 2'd0);
    pop     = vld_out && out_rdy;
    need    = {1'b0, fcnt} + {2'b0, pend}
            + 3'd1 - {2'b0, pop};
    credit  = (need <= 3'd2);
    rd_act  = (rst_st == FULL) || (rst_st == DRAINING);
    issue   = rd_act && credit;
    rfin    = issue && (rcnt == 6'd63);
    zaddr   = zz(rcnt);
    dout    = fd[head];
    blk_last = fl[head];
    tail    = head ^ fcnt[0];
    pdata   = pend_bank ? b1_dout : b0_dout;
  end

  // Per-bank state transitions from writer and reader
  always_comb begin
    st0_nxt = st0;
    st1_nxt = st1;
    if (accept) begin
      if (wr_bank) st1_nxt = wfin ? FULL : FILLING;
      else         st0_nxt = wfin ? FULL : FILLING;
    end
    if (issue) begin
      if (rd_bank) st1_nxt = rfin ? EMPTY : DRAINING;
      else         st0_nxt = rfin ? EMPTY : DRAINING;
    end
  end

  // Bank control driven straight from the current cycle's decisions
  always_comb begin
    wsel0   = accept && !wr_bank;
    wsel1   = accept && wr_bank;
    rsel0   = issue && !rd_bank;
    rsel1   = issue && rd_bank;
    b0_cs_n = !(wsel0 || rsel0);
    b0_w_en = wsel0;
    b0_r_en = rsel0;
    b0_addr = wsel0 ? wcnt : (rsel0 ? zaddr : 6'd0);
    b0_din  = wsel0 ? din : '0;
    b1_cs_n = !(wsel1 || rsel1);
    b1_w_en = wsel1;
    b1_r_en = rsel1;
    b1_addr = wsel1 ? wcnt : (rsel1 ? zaddr : 6'd0);
    b1_din  = wsel1 ? din : '0;
  end

  // Bank FSMs, pointers, counters, read pipe and output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0       <= EMPTY;
      st1       <= EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wcnt      <= 6'd0;
      rcnt      <= 6'd0;
      pend      <= 1'b0;
      pend_bank <= 1'b0;
      pend_last <= 1'b0;
      head      <= 1'b0;
      fcnt      <= 2'd0;
      fd[0]     <= '0;
      fd[1]     <= '0;
      fl[0]     <= 1'b0;
      fl[1]     <= 1'b0;
    end else begin
      st0 <= st0_nxt;
      st1 <= st1_nxt;
      if (accept) begin
        wcnt <= wcnt + 6'd1;
        if (wfin) wr_bank <= ~wr_bank;
      end
      if (issue) begin
        rcnt <= rcnt + 6'd1;
        if (rfin) rd_bank <= ~rd_bank;
      end
      pend      <= issue;
      pend_bank <= rd_bank;
      pend_last <= (rcnt == 6'd63);
      if (pend) begin
        fd[tail] <= pdata;
        fl[tail] <= pend_last;
      end
      head <= head ^ pop;
      fcnt <= fcnt + {1'b0, pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_zigzag_pingpong_ctrl.sv
// Directed bench for zigzag_pingpong_ctrl.
// Models both banks and checks zigzag order.
module tb_zigzag_pingpong_ctrl;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld_in = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] din = '0;
  logic          vld_out;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] dout;
  logic          blk_last;
  logic          b0_cs_n, b0_w_en, b0_r_en;
  logic          b1_cs_n, b1_w_en, b1_r_en;
  logic [5:0]    b0_addr, b1_addr;
  logic [DW-1:0] b0_din, b1_din;
  logic [DW-1:0] b0_dout = '0;
  logic [DW-1:0] b1_dout = '0;

  zigzag_pingpong_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vld_in(vld_in), .in_rdy(in_rdy), .din(din),
    .vld_out(vld_out), .out_rdy(out_rdy),
    .dout(dout), .blk_last(blk_last),
    .b0_cs_n(b0_cs_n), .b0_w_en(b0_w_en),
    .b0_r_en(b0_r_en), .b0_addr(b0_addr),
    .b0_din(b0_din), .b0_dout(b0_dout),
    .b1_cs_n(b1_cs_n), .b1_w_en(b1_w_en),
    .b1_r_en(b1_r_en), .b1_addr(b1_addr),
    .b1_din(b1_din), .b1_dout(b1_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem0 [64];
  logic [DW-1:0] mem1 [64];

  always @(posedge clk) begin
    if (!b0_cs_n) begin
      if (b0_w_en) mem0[b0_addr] <= b0_din;
      if (b0_r_en) b0_dout <= mem0[b0_addr];
    end
    if (!b1_cs_n) begin
      if (b1_w_en) mem1[b1_addr] <= b1_din;
      if (b1_r_en) b1_dout <= mem1[b1_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int zz [64];
  int last_acc = 0;
  int rd_iss = 0;
  int co1 = 0, co2 = 0, co1_c = 0, co2_c = 0;
  logic [DW-1:0] obs_d [$];
  logic          obs_l [$];
  int            obs_c [$];

  always @(negedge clk) begin
    if (rst_n && vld_out && out_rdy) begin
      obs_d.push_back(dout);
      obs_l.push_back(blk_last);
      obs_c.push_back(cyc);
    end
    if ((!b0_cs_n && b0_r_en) || (!b1_cs_n && b1_r_en))
      rd_iss++;
    if (!b1_cs_n && b1_w_en && b1_addr == 6'd63 &&
        !b0_cs_n && b0_r_en && b0_addr == 6'd63) begin
      co1++;
      co1_c = cyc;
    end
    if (!b0_cs_n && b0_w_en && b0_addr == 6'd0 &&
        !b1_cs_n && b1_r_en && b1_addr == 6'd0) begin
      co2++;
      co2_c = cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d",
             tag, got, exp);
    end
  endtask

  task automatic clr();
    obs_d.delete();
    obs_l.delete();
    obs_c.delete();
    rd_iss = 0;
    co1 = 0;
    co2 = 0;
  endtask

  task automatic do_reset();
    vld_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
  endtask

  task automatic feed(input int base, input int n,
                      input int dens, input int maxc,
                      output int acc_n, output int stalls);
    acc_n = 0;
    stalls = 0;
    for (int c = 0; c < maxc && acc_n < n; c++) begin
      vld_in = ($urandom_range(0, 99) < dens);
      din = DW'(base + acc_n);
      @(negedge clk);
      if (vld_in && !in_rdy) stalls++;
      if (vld_in && in_rdy) begin
        acc_n++;
        last_acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    vld_in = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input int n,
                           input int maxc);
    for (int c = 0; c < maxc && obs_d.size() < n; c++)
      @(posedge clk);
    #1;
    check(tag, obs_d.size(), n);
  endtask

  task automatic check_blocks(input string tag,
                              input int nb, input int base);
    int e;
    for (int j = 0; j < nb * 64 && j < obs_d.size(); j++) begin
      e = base + 64 * (j / 64) + zz[j % 64];
      check({tag, "_data"}, obs_d[j], e);
      check({tag, "_last"}, obs_l[j], (j % 64) == 63);
    end
  endtask

  function automatic int span(input int n);
    if (obs_c.size() < n) return -1;
    return obs_c[n-1] - obs_c[0];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_rdy"}, in_rdy, 1);
    check({tag, "_vld_out"}, vld_out, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_blk_last"}, blk_last, 0);
    check({tag, "_cs"}, {b0_cs_n, b1_cs_n}, 2'b11);
    check({tag, "_wen"}, {b0_w_en, b1_w_en}, 2'b00);
    check({tag, "_ren"}, {b0_r_en, b1_r_en}, 2'b00);
    check({tag, "_addr"}, {b0_addr, b1_addr}, 12'd0);
  endtask

  initial begin
    int a, s, r, c;
    r = 0;
    c = 0;
    for (int k = 0; k < 64; k++) begin
      zz[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end

    // reset values
    do_reset();
    @(negedge clk);
    check_idle("reset");

    // single block, latency and contiguity
    @(posedge clk); #1;
    out_rdy = 1'b1;
    feed(0, 64, 100, 200, a, s);
    check("single_acc", a, 64);
    wait_outs("single_cnt", 64, 200);
    check("single_lat", obs_c.size() > 0 ?
          obs_c[0] - last_acc : -1, 3);
    check("single_span", span(64), 63);
    check_blocks("single", 1, 0);

    // three back-to-back blocks
    do_reset();
    feed(0, 192, 100, 400, a, s);
    check("b2b_acc", a, 192);
    check("b2b_stall", s, 0);
    wait_outs("b2b_cnt", 192, 300);
    check("b2b_span", span(192), 191);
    check_blocks("b2b", 3, 0);
    check("edge_co1", co1, 1);
    check("edge_co2", co2, 1);
    check("edge_seq", co2_c - co1_c, 1);

    // downstream stalled, both banks fill
    do_reset();
    out_rdy = 1'b0;
    feed(0, 200, 100, 300, a, s);
    @(negedge clk);
    check("stall_acc", a, 128);
    check("stall_in_rdy", in_rdy, 0);
    check("stall_vld", vld_out, 1);
    check("stall_dout", dout, 0);
    check("stall_reads", rd_iss, 2);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    feed(128, 72, 100, 2000, a, s);
    check("stall_rest", a, 72);
    wait_outs("stall_cnt", 192, 500);
    check_blocks("stall", 3, 0);

    // random gaps on both sides, 10 blocks
    do_reset();
    fork
      feed(0, 640, 50, 8000, a, s);
      begin
        for (int k = 0; k < 20000 && obs_d.size() < 640; k++) begin
          out_rdy = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
        out_rdy = 1'b1;
      end
    join
    check("rand_acc", a, 640);
    wait_outs("rand_cnt", 640, 200);
    repeat (10) @(posedge clk);
    #1;
    check("rand_nodup", obs_d.size(), 640);
    check_blocks("rand", 10, 0);

    // reset mid-operation, then a fresh block
    do_reset();
    out_rdy = 1'b1;
    feed(0, 94, 100, 300, a, s);
    @(negedge clk);
    check("mid_busy", vld_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr();
    feed(900, 64, 100, 200, a, s);
    check("fresh_acc", a, 64);
    wait_outs("fresh_cnt", 64, 200);
    repeat (10) @(posedge clk);
    #1;
    check("fresh_nodup", obs_d.size(), 64);
    check_blocks("fresh", 1, 900);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
